// File: rtl/filter_block.sv
// Two-stage pipelined x4 scaling filter on a valid/parity-tagged sample stream.
// Each stage doubles the sample and folds its bit parity into the running tag.

module filter_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  input  logic             parity_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             parity_q, parity_d;

  // Data and parity only advance on a valid sample so bubbles leave the last value visible.
  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    valid_d  = valid_i;
    if (valid_i) begin
      data_d   = {data_i[WIDTH-2:0], 1'b0};
      parity_d = parity_i ^ (^data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      parity_q <= parity_d;
    end
  end

  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign parity_o = parity_q;

endmodule

module filter_block #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid,
  input  logic             x_parity,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  output logic             y_parity
);

  localparam int STAGES = 2;

  // Index 0 is the input; index g+1 is the output of stage g.
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            par_pipe;

  assign data_pipe[0] = x_data;
  assign vld_pipe[0]  = x_valid;
  assign par_pipe[0]  = x_parity;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    filter_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .data_i   (data_pipe[g]),
      .valid_i  (vld_pipe[g]),
      .parity_i (par_pipe[g]),
      .data_o   (data_pipe[g+1]),
      .valid_o  (vld_pipe[g+1]),
      .parity_o (par_pipe[g+1])
    );
  end

  assign y_data   = data_pipe[STAGES];
  assign y_valid  = vld_pipe[STAGES];
  assign y_parity = par_pipe[STAGES];

endmodule

// File: tb/tb_filter_block.sv
// Directed bench for filter_block: reset, latency, parity folding, wrap, bubbles, mid-stream reset.

module tb_filter_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] x_data;
  logic        x_valid;
  logic        x_parity;
  logic [15:0] y_data;
  logic        y_valid;
  logic        y_parity;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_block #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .x_data   (x_data),
    .x_valid  (x_valid),
    .x_parity (x_parity),
    .y_data   (y_data),
    .y_valid  (y_valid),
    .y_parity (y_parity)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] d, input logic v, input logic p);
    n_assert++;
    assert ({y_data, y_valid, y_parity} === {d, v, p})
    else begin
      n_fail++;
      $error("FAIL %s observed data=%h valid=%b parity=%b expected data=%h valid=%b parity=%b",
             tag, y_data, y_valid, y_parity, d, v, p);
    end
  endtask

  initial begin
    rst = 1'b1; x_data = 16'd0; x_valid = 1'b0; x_parity = 1'b0;
    step();
    rst = 1'b0;
    chk("reset_edge", 16'd0, 1'b0, 1'b0);
    step();
    chk("reset_idle", 16'd0, 1'b0, 1'b0);

    // Sample 3, parity 0, held valid
    x_data = 16'd3; x_valid = 1'b1; x_parity = 1'b0;
    #1;
    chk("lat_before_edge", 16'd0, 1'b0, 1'b0);
    step();
    chk("lat_after_1st", 16'd0, 1'b0, 1'b0);
    step();
    chk("lat_after_2nd", 16'd12, 1'b1, 1'b0);

    // Sample 5 with parity tag 1, one cycle
    x_data = 16'd5; x_parity = 1'b1;
    step();
    chk("held_3", 16'd12, 1'b1, 1'b0);
    x_valid = 1'b0; x_data = 16'hFFFF; x_parity = 1'b0;
    step();
    chk("par_5", 16'd20, 1'b1, 1'b1);
    step();
    chk("bubble_hold_5", 16'd20, 1'b0, 1'b1);

    // Overflow wrap: 0x4001 -> 0x0004
    x_data = 16'h4001; x_valid = 1'b1; x_parity = 1'b0;
    step();
    x_valid = 1'b0; x_data = 16'h0000;
    step();
    chk("wrap_4001", 16'h0004, 1'b1, 1'b0);
    step();
    chk("wrap_hold", 16'h0004, 1'b0, 1'b0);

    // Wrap with parity changes: 0xC003 p=1 -> s1 0x8006 p=1 -> y 0x000C p=0
    x_data = 16'hC003; x_valid = 1'b1; x_parity = 1'b1;
    step();
    x_valid = 1'b0;
    step();
    chk("wrap_C003", 16'h000C, 1'b1, 1'b0);

    // Back-to-back 1,2,3 then bubble
    x_data = 16'd1; x_valid = 1'b1; x_parity = 1'b0;
    step();
    chk("b2b_pre", 16'h000C, 1'b0, 1'b0);
    x_data = 16'd2;
    step();
    chk("b2b_1", 16'd4, 1'b1, 1'b0);
    x_data = 16'd3;
    step();
    chk("b2b_2", 16'd8, 1'b1, 1'b0);
    x_valid = 1'b0; x_data = 16'd9; x_parity = 1'b1;
    step();
    chk("b2b_3", 16'd12, 1'b1, 1'b0);
    step();
    chk("b2b_bubble", 16'd12, 1'b0, 1'b0);
    step();
    chk("b2b_bubble2", 16'd12, 1'b0, 1'b0);

    // Mid-stream reset: 7 emerges, 9 and 11 are discarded
    x_data = 16'd7; x_valid = 1'b1; x_parity = 1'b0;
    step();
    x_data = 16'd9;
    step();
    chk("pre_rst_7", 16'd28, 1'b1, 1'b0);
    x_data = 16'd11; rst = 1'b1;
    step();
    chk("rst_flush", 16'd0, 1'b0, 1'b0);
    rst = 1'b0; x_valid = 1'b0;
    step();
    chk("rst_no_stale1", 16'd0, 1'b0, 1'b0);
    step();
    chk("rst_no_stale2", 16'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
